// File: rtl/lift_pkg.sv
// Shared lift types: FSM states, direction codes, one-hot floors.
// Also used by the floor display block.
package lift_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_MOVE_UP   = 2'd1,
      S_MOVE_DOWN = 2'd2,
      S_DOOR_OPEN = 2'd3
   } state_t;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   localparam logic [2:0] FLOOR0 = 3'b001;
   localparam logic [2:0] FLOOR1 = 3'b010;
   localparam logic [2:0] FLOOR2 = 3'b100;

   // Floors strictly above / below a one-hot floor
   function automatic logic [2:0] above_mask(input logic [2:0] fl);
      return ~(fl | (fl - 3'd1));
   endfunction

   function automatic logic [2:0] below_mask(input logic [2:0] fl);
      return fl - 3'd1;
   endfunction

endpackage

// File: rtl/lift_timer.sv
// Cycle timer for travel and door phases.
// Load restarts at zero; done flags the final count.
module lift_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] limit,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign done = (count == limit);

endmodule

// File: rtl/lift_scheduler.sv
// Three-floor lift scheduler: call latching, travel and door FSM.
// One timer is shared since travel and door phases never overlap.
module lift_scheduler
   import lift_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] call_req,
   output logic [2:0] floor_state,
   output logic [1:0] direction,
   output logic       door_open,
   output logic [2:0] pending,
   output logic       busy
);

   localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                         TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] TRAVEL_LIM = CW'(TRAVEL_CYCLES - 1);
   localparam logic [CW-1:0] DOOR_LIM   = CW'(DOOR_CYCLES - 1);

   state_t      state, state_nx;
   logic [2:0]  floor_nx, pend_nx, pend_in;
   logic [2:0]  look_floor, look_pend;
   logic        last_up, last_up_nx;
   logic        in_door, door_restart, decide, pref_up;
   logic        up_p, dn_p;
   logic        tmr_load, tmr_done;
   logic [CW-1:0] tmr_limit;

   lift_timer #(.W(CW)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .limit (tmr_limit),
      .done  (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         floor_state <= FLOOR0;
         pending     <= 3'b000;
         last_up     <= 1'b1;
      end else begin
         state       <= state_nx;
         floor_state <= floor_nx;
         pending     <= pend_nx;
         last_up     <= last_up_nx;
      end
   end

   always_comb begin
      in_door      = (state == S_DOOR_OPEN);
      door_restart = in_door && |(call_req & floor_state);
      // A call to the open-door floor only holds the door
      pend_in      = pending |
                     (call_req & ~(in_door ? floor_state : 3'b000));
      state_nx     = state;
      floor_nx     = floor_state;
      pend_nx      = pend_in;
      last_up_nx   = last_up;
      decide       = 1'b0;
      look_floor   = floor_state;
      look_pend    = pending;
      pref_up      = 1'b1;
      unique case (state)
         S_IDLE: begin
            decide = 1'b1;
         end
         S_MOVE_UP: begin
            decide     = tmr_done;
            look_floor = {floor_state[1:0], 1'b0};
            look_pend  = pend_in;
            pref_up    = 1'b1;
         end
         S_MOVE_DOWN: begin
            decide     = tmr_done;
            look_floor = {1'b0, floor_state[2:1]};
            look_pend  = pend_in;
            pref_up    = 1'b0;
         end
         S_DOOR_OPEN: begin
            decide  = tmr_done && !door_restart;
            pref_up = last_up;
         end
      endcase
      up_p = |(look_pend & above_mask(look_floor));
      dn_p = |(look_pend & below_mask(look_floor));
      if (decide) begin
         floor_nx = look_floor;
         if (|(look_pend & look_floor)) begin
            state_nx = S_DOOR_OPEN;
            pend_nx  = pend_in & ~look_floor;
         end else if (up_p && (pref_up || !dn_p)) begin
            state_nx   = S_MOVE_UP;
            last_up_nx = 1'b1;
         end else if (dn_p) begin
            state_nx   = S_MOVE_DOWN;
            last_up_nx = 1'b0;
         end else begin
            state_nx = S_IDLE;
         end
      end
   end

   assign tmr_load  = (state == S_IDLE) || tmr_done || door_restart;
   assign tmr_limit = in_door ? DOOR_LIM : TRAVEL_LIM;

   always_comb begin
      direction = DIR_IDLE;
      if (state == S_MOVE_UP)   direction = DIR_UP;
      if (state == S_MOVE_DOWN) direction = DIR_DOWN;
   end

   assign door_open = (state == S_DOOR_OPEN);
   assign busy      = (state != S_IDLE) || (|pending);

endmodule

// File: tb/tb_lift_scheduler.sv
// Directed bench for lift_scheduler (TRAVEL_CYCLES=8, DOOR_CYCLES=4).
// Cycle c is observed 1 time unit after the edge that starts it.
module tb_lift_scheduler;

   logic       clk;
   logic       rst_n;
   logic [2:0] call_req;
   logic [2:0] floor_state;
   logic [1:0] direction;
   logic       door_open;
   logic [2:0] pending;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   lift_scheduler #(
      .TRAVEL_CYCLES (8),
      .DOOR_CYCLES   (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .call_req    (call_req),
      .floor_state (floor_state),
      .direction   (direction),
      .door_open   (door_open),
      .pending     (pending),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst_n    = 1'b0;
      call_req = 3'b111;
      repeat (2) tick();
      call_req = 3'b000;
      rst_n    = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      call_req = 3'b000;

      // reset with all calls asserted
      hold_reset();
      chk("rst_floor", 32'(floor_state), 32'(3'b001));
      chk("rst_dir",   32'(direction),   32'(2'b00));
      chk("rst_door",  32'(door_open),   32'(1'b0));
      chk("rst_pend",  32'(pending),     32'(3'b000));
      chk("rst_busy",  32'(busy),        32'(1'b0));

      // floor0 -> floor2
      hold_reset();
      for (int c = 0; c <= 22; c++) begin
         logic [1:0] ed;
         logic [2:0] ef;
         ed = (c >= 2 && c <= 17) ? 2'b01 : 2'b00;
         ef = (c < 10) ? 3'b001 : (c < 18) ? 3'b010 : 3'b100;
         chk($sformatf("up2_dir_c%0d", c), 32'(direction), 32'(ed));
         chk($sformatf("up2_flr_c%0d", c), 32'(floor_state), 32'(ef));
         chk($sformatf("up2_door_c%0d", c), 32'(door_open),
             32'(c >= 18 && c <= 21));
         if (c == 1) chk("up2_busy_c1", 32'(busy), 32'(1'b1));
         if (c == 22) begin
            chk("up2_pend_c22", 32'(pending), 32'(3'b000));
            chk("up2_busy_c22", 32'(busy), 32'(1'b0));
         end
         call_req = (c == 0) ? 3'b100 : 3'b000;
         tick();
      end

      // same-floor call, door extended by a repeat call
      hold_reset();
      for (int c = 0; c <= 10; c++) begin
         chk($sformatf("same_door_c%0d", c), 32'(door_open),
             32'(c >= 2 && c <= 8));
         chk($sformatf("same_dir_c%0d", c), 32'(direction), 32'(2'b00));
         chk($sformatf("same_flr_c%0d", c), 32'(floor_state),
             32'(3'b001));
         chk($sformatf("same_pend_c%0d", c), 32'(pending),
             32'((c == 1) ? 3'b001 : 3'b000));
         call_req = (c == 0 || c == 4) ? 3'b001 : 3'b000;
         tick();
      end

      // intermediate stop at floor1 on the way up
      hold_reset();
      for (int c = 0; c <= 26; c++) begin
         logic [1:0] ed;
         logic [2:0] ef, ep;
         ed = ((c >= 2 && c <= 9) || (c >= 14 && c <= 21)) ?
              2'b01 : 2'b00;
         ef = (c < 10) ? 3'b001 : (c < 22) ? 3'b010 : 3'b100;
         ep = (c == 0) ? 3'b000 :
              (c <= 5) ? 3'b100 :
              (c <= 9) ? 3'b110 :
              (c <= 21) ? 3'b100 : 3'b000;
         chk($sformatf("mid_dir_c%0d", c), 32'(direction), 32'(ed));
         chk($sformatf("mid_flr_c%0d", c), 32'(floor_state), 32'(ef));
         chk($sformatf("mid_door_c%0d", c), 32'(door_open),
             32'((c >= 10 && c <= 13) || (c >= 22 && c <= 25)));
         chk($sformatf("mid_pend_c%0d", c), 32'(pending), 32'(ep));
         call_req = (c == 0) ? 3'b100 :
                    (c == 5) ? 3'b010 : 3'b000;
         tick();
      end

      // from floor1: calls both ways, up served first
      hold_reset();
      for (int c = 0; c <= 48; c++) begin
         case (c)
            14: begin
               chk("both_idle_flr", 32'(floor_state), 32'(3'b010));
               chk("both_idle_dir", 32'(direction), 32'(2'b00));
               chk("both_idle_door", 32'(door_open), 32'(1'b0));
            end
            15: chk("both_pend", 32'(pending), 32'(3'b101));
            16: chk("both_dir_up", 32'(direction), 32'(2'b01));
            24: begin
               chk("both_flr2", 32'(floor_state), 32'(3'b100));
               chk("both_door2", 32'(door_open), 32'(1'b1));
               chk("both_pend2", 32'(pending), 32'(3'b001));
            end
            28: chk("both_dir_dn", 32'(direction), 32'(2'b10));
            36: begin
               chk("both_pass_flr1", 32'(floor_state), 32'(3'b010));
               chk("both_pass_dir", 32'(direction), 32'(2'b10));
            end
            44: begin
               chk("both_flr0", 32'(floor_state), 32'(3'b001));
               chk("both_door0", 32'(door_open), 32'(1'b1));
               chk("both_pend0", 32'(pending), 32'(3'b000));
            end
            48: begin
               chk("both_end_dir", 32'(direction), 32'(2'b00));
               chk("both_end_busy", 32'(busy), 32'(1'b0));
               chk("both_end_pend", 32'(pending), 32'(3'b000));
            end
            default: ;
         endcase
         call_req = (c == 0)  ? 3'b010 :
                    (c == 14) ? 3'b101 : 3'b000;
         tick();
      end

      // reset pulse during travel
      hold_reset();
      for (int c = 0; c <= 7; c++) begin
         if (c == 3) chk("mrst_dir_pre", 32'(direction), 32'(2'b01));
         if (c == 5) chk("mrst_busy_pre", 32'(busy), 32'(1'b1));
         if (c == 6 || c == 7) begin
            chk($sformatf("mrst_flr_c%0d", c), 32'(floor_state),
                32'(3'b001));
            chk($sformatf("mrst_dir_c%0d", c), 32'(direction),
                32'(2'b00));
            chk($sformatf("mrst_pend_c%0d", c), 32'(pending),
                32'(3'b000));
            chk($sformatf("mrst_door_c%0d", c), 32'(door_open),
                32'(1'b0));
            chk($sformatf("mrst_busy_c%0d", c), 32'(busy),
                32'(1'b0));
         end
         rst_n    = (c == 5) ? 1'b0 : 1'b1;
         call_req = (c == 0) ? 3'b100 : 3'b000;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lift_scheduler.md
LIFT_SCHEDULER -- requirements
Module: lift_scheduler

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8: clock cycles the cabin spends moving between adjacent floors (>=2).
REQ-002 Parameter DOOR_CYCLES, default 4: clock cycles the door stays open per stop (>=1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 call_req  input  3  floor call pulses; bit0=floor0, bit1=floor1, bit2=floor2; several bits may be set together.
REQ-006 floor_state  output  3  one-hot current cabin floor: 001=floor0, 010=floor1, 100=floor2; drives the display block.
REQ-007 direction  output  2  00=idle/stopped, 01=moving up, 10=moving down; 11 never driven.
REQ-008 door_open  output  1  high while the cabin is stopped with the door open.
REQ-009 pending  output  3  registered outstanding calls, same bit order as call_req.
REQ-010 busy  output  1  high whenever the state is not IDLE or pending is non-zero.

Function
REQ-011 State machine SHALL have exactly the states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
REQ-012 pending[i] SHALL be set at the edge after call_req[i]=1, except for a call to the current floor while in DOOR_OPEN (see REQ-019).
REQ-013 pending[i] SHALL be cleared at the edge that enters DOOR_OPEN at floor i; a simultaneous call_req[i] in that cycle is absorbed (pending[i] stays 0).
REQ-014 IDLE: next-state decision uses the registered pending only; priority: pending at current floor -> DOOR_OPEN; else pending above -> MOVE_UP; else pending below -> MOVE_DOWN; else stay IDLE. Up wins over down when both exist.
REQ-015 Latency: call_req pulse in cycle N from IDLE SHALL give direction!=00 or door_open=1 in cycle N+2.
REQ-016 MOVE_*: a travel counter SHALL count 0..TRAVEL_CYCLES-1 starting at 0 on entry; at the edge ending count TRAVEL_CYCLES-1, floor_state shifts one position (left for up, right for down) and the counter restarts.
REQ-017 Arrival decision (made in that edge, using the new floor and pending including same-cycle call_req): pending at new floor -> DOOR_OPEN; else pending further in the same direction -> stay in MOVE_*; else pending in the opposite direction -> opposite MOVE_*; else IDLE.
REQ-018 DOOR_OPEN: door_open=1, direction=00, floor_state held; a door counter counts 0..DOOR_CYCLES-1, then the IDLE priority of REQ-014 is applied at that edge (same direction preferred when pending exists both ways, up if last direction unknown).
REQ-019 call_req for the current floor during DOOR_OPEN SHALL restart the door counter at 0 and SHALL NOT set pending.
REQ-020 MOVE_UP SHALL never be entered at floor2 nor MOVE_DOWN at floor0; floor_state SHALL always be one-hot.
REQ-021 direction SHALL be 01 in MOVE_UP, 10 in MOVE_DOWN, 00 otherwise; all outputs registered or decoded from registered state only.

Reset
REQ-022 When rst_n=0 at a rising edge: state=IDLE, floor_state=001, direction=00, door_open=0, pending=000, busy=0, counters=0, last direction=up; call_req ignored in that cycle.
REQ-023 Reset mid-travel or mid-door SHALL abandon the operation; cabin floor re-initialises to floor0 (no position recovery).

Structure
REQ-024 State encoding, direction codes (IDLE/UP/DOWN) and one-hot floor constants SHALL live in shared package lift_pkg, also used by the display block.
REQ-025 One sub-module lift_timer (loadable down/up counter with done flag) SHALL be instantiated for travel and door timing; everything else stays in lift_scheduler.

Verification (TRAVEL_CYCLES=8, DOOR_CYCLES=4, cycle 0 = first cycle after reset release)
REQ-026 Reset: hold rst_n=0 with call_req=111 -> floor_state=001, direction=00, door_open=0, pending=000, busy=0.
REQ-027 At floor0 pulse call_req=100 in cycle 0 -> direction=01 cycles 2-17, floor_state=010 at cycle 10, 100 at cycle 18, door_open=1 cycles 18-21, IDLE/pending=000 at cycle 22.
REQ-028 At floor0 idle pulse call_req=001 -> door_open=1 cycles 2-5, direction stays 00, floor_state stays 001; second 001 pulse in cycle 4 extends door_open through cycle 8.
REQ-029 Call 100 in cycle 0, call 010 in cycle 5 -> stop at floor1 with door_open cycles 10-13, direction=01 again from cycle 14, floor2 reached cycle 22.
REQ-030 Idle at floor1, call_req=101 in one cycle -> goes up first, serves floor2, then direction=10 and serves floor0; pending ends 000.
REQ-031 rst_n=0 for one cycle during MOVE_UP -> next cycle floor_state=001, direction=00, pending=000, door_open=0.
